// File: rtl/jukebox_pkg.sv
// Shared types for the jukebox audio blocks: phase-count width, period-meter
// FSM states and a saturating counter helper.
package jukebox_pkg;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    ARM  = 3'd2,
    HIGH = 3'd3,
    LOW  = 3'd4
  } state_t;

  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
    return (v < lim) ? v + 32'd1 : lim;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus a history flop; rise/fall are decoded from the
// last two synchronised samples, so both polarities lag d by the same amount.
module sync_edge_detect (
  input  logic inclk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic hist_r;

  // synchroniser chain and edge history
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      hist_r <= 1'b0;
    end else begin
      s1_r   <= d;
      s2_r   <= s1_r;
      hist_r <= s2_r;
    end
  end

  assign rise = s2_r & ~hist_r;
  assign fall = ~s2_r & hist_r;

endmodule

// File: rtl/period_meter.sv
// Measures the high and low phase lengths of an asynchronous square wave and
// reports them as divider terminal counts (cycles - 1).
module period_meter
  import jukebox_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic             inclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             valid,
  output logic             symmetric,
  output logic             timeout
);

  state_t     state_r, state_s;
  cnt_t       cnt_r, cnt_s;
  cnt_t       high_tmp_r, high_tmp_s;
  cnt_t       high_cnt_s, low_cnt_s;
  logic       sym_s, timeout_s, valid_s;
  logic       rise_s, fall_s;

  sync_edge_detect u_sync (
    .inclk (inclk),
    .rst_n (rst_n),
    .d     (sig_in),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // next-state and result computation; an edge always beats the timeout
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    high_tmp_s = high_tmp_r;
    high_cnt_s = high_cnt;
    low_cnt_s  = low_cnt;
    sym_s      = symmetric;
    timeout_s  = timeout;
    valid_s    = 1'b0;
    if (!en) begin
      state_s = IDLE;
      cnt_s   = 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = SYNC;
          cnt_s   = 32'd0;
        end
        SYNC: begin
          if (fall_s) state_s = ARM;
          else        state_s = SYNC;
        end
        ARM: begin
          if (rise_s) begin
            state_s = HIGH;
            cnt_s   = 32'd0;
          end else begin
            state_s = ARM;
          end
        end
        HIGH: begin
          if (fall_s) begin
            state_s    = LOW;
            high_tmp_s = cnt_r;
            cnt_s      = 32'd0;
          end else if (cnt_r == TIMEOUT) begin
            state_s   = SYNC;
            timeout_s = 1'b1;
            cnt_s     = 32'd0;
          end else begin
            cnt_s = sat_inc(cnt_r, TIMEOUT);
          end
        end
        LOW: begin
          if (rise_s) begin
            state_s    = HIGH;
            high_cnt_s = high_tmp_r;
            low_cnt_s  = cnt_r;
            sym_s      = (high_tmp_r == cnt_r);
            timeout_s  = 1'b0;
            valid_s    = 1'b1;
            cnt_s      = 32'd0;
          end else if (cnt_r == TIMEOUT) begin
            state_s   = SYNC;
            timeout_s = 1'b1;
            cnt_s     = 32'd0;
          end else begin
            cnt_s = sat_inc(cnt_r, TIMEOUT);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 32'd0;
        end
      endcase
    end
  end

  // FSM state and phase counters
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 32'd0;
      high_tmp_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      high_tmp_r <= high_tmp_s;
    end
  end

  // registered measurement outputs
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt  <= 32'd0;
      low_cnt   <= 32'd0;
      symmetric <= 1'b0;
      timeout   <= 1'b0;
      valid     <= 1'b0;
    end else begin
      high_cnt  <= high_cnt_s;
      low_cnt   <= low_cnt_s;
      symmetric <= sym_s;
      timeout   <= timeout_s;
      valid     <= valid_s;
    end
  end

endmodule
